ahb_mem_bridge: RTL

//  AHB-Lite subordinate that turns pipelined AHB transfers into single memory requests.

---
 rtl/ahb_mem_bridge.sv | 114 +++++++++++
 1 files changed

// File: rtl/ahb_mem_bridge.sv
// AHB-Lite subordinate that converts each AHB transfer into one memory request.
// It also generates wait states, the two-cycle ERROR response and a response timeout.
module ahb_mem_bridge #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 HSEL,
  input  logic [AddrWidth-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [DataWidth-1:0] HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [DataWidth-1:0] HRDATA,
  output logic                 memReq,
  output logic [AddrWidth-1:0] addr,
  output logic [DataWidth-1:0] wData,
  output logic                 write,
  input  logic [1:0]           resp,
  input  logic [DataWidth-1:0] rData
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DataWidth / 8));
  localparam int CNT_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             unused_htrans0;

  function automatic logic legal_xfer(input logic [2:0] size, input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] mask;
    mask = (AddrWidth'(1) << size) - AddrWidth'(1);
    return (size <= MAX_SIZE) && ((a & mask) == '0);
  endfunction

  // Only the NONSEQ/SEQ distinction from IDLE/BUSY matters, so HTRANS[0] is not decoded.
  assign unused_htrans0 = HTRANS[0];
  assign capture = HSEL & HREADY & HTRANS[1] &
                   ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR2));
  assign wData = HWDATA;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      memReq    <= 1'b0;
      addr      <= '0;
      write     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_ACCESS: begin
          if (resp == 2'b01) begin
            state     <= S_DONE;
            HREADYOUT <= 1'b1;
            memReq    <= 1'b0;
            cnt       <= '0;
            if (!write) HRDATA <= rData;
          end else if (resp[1] || ((TimeoutCycles != 0) && (cnt == TO_LAST))) begin
            state     <= S_ERR1;
            HRESP     <= 1'b1;
            memReq    <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all accept a new address phase.
          if (capture) begin
            addr      <= HADDR;
            write     <= HWRITE;
            HREADYOUT <= 1'b0;
            if (legal_xfer(HSIZE, HADDR)) begin
              state  <= S_ACCESS;
              memReq <= 1'b1;
              HRESP  <= 1'b0;
            end else begin
              state  <= S_ERR1;
              HRESP  <= 1'b1;
            end
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
